bus_arbiter: RTL

Snooping-bus arbiter and transaction sequencer sitting directly upstream of the memory controller. It collects coherence requests from the NUM_CPUS private caches, grants one at a time in round-robin order, and broadcasts the winner as a single-cycle `bus_msg_t` to every snooper and to memory. It then holds the bus until the requester signals its fill is complete, so at most one transaction is in flight.

---
 rtl/bus_arbiter_pkg.sv | 35 +++
 rtl/bus_arbiter_rr.sv | 33 +++
 rtl/bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared coherence-bus types: request/broadcast structs, transaction kinds
// and arbiter FSM states used by bus_arbiter and its round-robin picker.
package bus_arbiter_pkg;

  localparam int NUM_CPUS_DEF = 4;
  localparam int ADDR_W       = 32;
  // Wide enough for up to 16 requesters regardless of NUM_CPUS.
  localparam int SRC_W        = 4;

  typedef enum logic [1:0] {
    BusGetS = 2'd0,
    BusGetM = 2'd1,
    BusUpg  = 2'd2
  } bus_tx_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BCAST     = 2'd1,
    WAIT_FILL = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    bus_tx_t           bus_tx;
    logic [ADDR_W-1:0] addr;
  } bus_req_t;

  typedef struct packed {
    logic              valid;
    bus_tx_t           bus_tx;
    logic [ADDR_W-1:0] addr;
    logic [SRC_W-1:0]  source;
  } bus_msg_t;

endpackage

// File: rtl/bus_arbiter_rr.sv
// Combinational round-robin picker: the search starts one past rr_ptr and
// wraps, so the most recent winner has the lowest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] cand;

  // N is a power of two, so the PW-bit add wraps modulo N for free.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = rr_ptr + PW'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant, one-cycle broadcast, then hold the
// bus until the winner's fill completes. BUS_ARB_TIMEOUT_EN adds a watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_CPUS    = NUM_CPUS_DEF,
  parameter int ARB_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  bus_req_t [NUM_CPUS-1:0]   bus_req,
  input  logic     [NUM_CPUS-1:0]   fill_done,
  output logic     [NUM_CPUS-1:0]   grant,
  output bus_msg_t                  bus_msg,
  output logic                      bus_busy,
  output logic                      timeout_err
);

  localparam int PW = $clog2(NUM_CPUS);

  if (NUM_CPUS < 2 || (NUM_CPUS & (NUM_CPUS - 1)) != 0 || ARB_TIMEOUT < 1) begin : g_bad_cfg
    $error("bus_arbiter: NUM_CPUS must be a power of 2 >= 2 and ARB_TIMEOUT >= 1");
  end

  arb_state_t        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     src_idx;
  logic              msg_valid;
  bus_tx_t           msg_tx;
  logic [ADDR_W-1:0] msg_addr;
  logic [NUM_CPUS-1:0] grant_q;
  logic              busy_q;
  logic              wd_expired;

  logic [NUM_CPUS-1:0] req_valid;
  logic [NUM_CPUS-1:0] arb_gnt;
  logic [PW-1:0]       arb_idx;
  logic                arb_any;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_CPUS; i++) begin
      req_valid[i] = bus_req[i].valid;
    end
  end

  rr_arbiter #(.N(NUM_CPUS)) u_rr (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Grant and msg valid are single-cycle pulses; payload fields hold until the next win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NUM_CPUS - 1);
      src_idx   <= '0;
      msg_valid <= 1'b0;
      msg_tx    <= BusGetS;
      msg_addr  <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      grant_q   <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state     <= BCAST;
            msg_valid <= 1'b1;
            grant_q   <= arb_gnt;
            msg_tx    <= bus_req[arb_idx].bus_tx;
            msg_addr  <= bus_req[arb_idx].addr;
            src_idx   <= arb_idx;
            rr_ptr    <= arb_idx;
            busy_q    <= 1'b1;
          end
        end
        BCAST: begin
          // A same-cycle memory response lets us skip WAIT_FILL entirely.
          if (fill_done[src_idx] || msg_tx == BusUpg) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state  <= WAIT_FILL;
          end
        end
        WAIT_FILL: begin
          if (fill_done[src_idx] || wd_expired) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(ARB_TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  assign wd_expired = (state == WAIT_FILL) && (wd_cnt + CW'(1) == CW'(ARB_TIMEOUT));

  // Counter is cleared while broadcasting so it starts at zero in WAIT_FILL;
  // a fill landing on the limit cycle wins over the error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == BCAST) begin
      wd_cnt <= '0;
    end else if (state == WAIT_FILL) begin
      wd_cnt <= wd_cnt + CW'(1);
      if (wd_expired && !fill_done[src_idx]) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = err_q;
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign grant    = grant_q;
  assign bus_busy = busy_q;
  assign bus_msg  = '{valid: msg_valid, bus_tx: msg_tx, addr: msg_addr,
                      source: SRC_W'(src_idx)};

endmodule
